// File: rtl/read_hazard_scoreboard.sv
// Per-register pending-write scoreboard gating the Read stage: counts in-flight writers per GPR.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle retiring writeback clear a source hazard.
module read_hazard_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readValidIn,
    input  logic                 stallIn,
    input  logic                 wbStallIn,
    input  logic [REG_IDX_W-1:0] sourceReg1In,
    input  logic                 sourceReg1ValidIn,
    input  logic [REG_IDX_W-1:0] sourceReg2In,
    input  logic                 sourceReg2ValidIn,
    input  logic [REG_IDX_W-1:0] destRegIn,
    input  logic                 destRegValidIn,
    input  logic [REG_IDX_W-1:0] destRegisterSpecialIn,
    input  logic                 destRegisterSpecialValidIn,
    input  logic                 wbValidIn,
    input  logic [REG_IDX_W-1:0] wbRegIn,
    input  logic                 wbSpecialValidIn,
    input  logic [REG_IDX_W-1:0] wbSpecialRegIn,
    input  logic                 flushIn,
    output logic                 canReadOut,
    output logic                 hazardStallOut,
    output logic [NUM_REGS-1:0]  pendingMaskOut,
    output logic                 busyOut,
    output logic                 underflowErrOut,
    output logic [31:0]          hazardCycleCountOut
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic                err_q, err_d;
    logic [31:0]         hcnt_q, hcnt_d;

    logic [NUM_REGS-1:0] wb_dec;
    logic [NUM_REGS-1:0] issue_inc;
    logic [NUM_REGS-1:0] src_blk;
    logic [NUM_REGS-1:0] dst_sat;
    logic                hazard;
    logic                req_ok;
    logic                grant;

    // Per-register decode of retirements, source blocking and destination saturation.
    always_comb begin
        wb_dec  = '0;
        src_blk = '0;
        dst_sat = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_dec[r] = !flushIn &&
                        ((wbValidIn        && (wbRegIn        == r[REG_IDX_W-1:0])) ||
                         (wbSpecialValidIn && (wbSpecialRegIn == r[REG_IDX_W-1:0])));
`ifdef SCOREBOARD_WB_BYPASS_EN
            src_blk[r] = (cnt_q[r] != '0) &&
                         !((cnt_q[r] == CNT_W'(1)) && wb_dec[r]);
`else
            src_blk[r] = (cnt_q[r] != '0);
`endif
            dst_sat[r] = (cnt_q[r] == CNT_MAX);
        end
    end

    // Read handshake: readValidIn offers an instruction; canReadOut is the grant and the
    // instruction is consumed (and its destinations counted) only in a cycle where both are high.
    always_comb begin
        hazard = (sourceReg1ValidIn          && src_blk[sourceReg1In]) ||
                 (sourceReg2ValidIn          && src_blk[sourceReg2In]) ||
                 (destRegValidIn             && dst_sat[destRegIn])    ||
                 (destRegisterSpecialValidIn && dst_sat[destRegisterSpecialIn]);
        req_ok = readValidIn && !stallIn && !wbStallIn && !flushIn;
        grant  = req_ok && !hazard;
    end

    assign canReadOut     = grant;
    assign hazardStallOut = req_ok && hazard;

    always_comb begin
        issue_inc = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            issue_inc[r] = grant &&
                           ((destRegValidIn && (destRegIn == r[REG_IDX_W-1:0])) ||
                            (destRegisterSpecialValidIn &&
                             (destRegisterSpecialIn == r[REG_IDX_W-1:0])));
        end
    end

    always_comb begin
        err_d  = err_q;
        mask_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flushIn) begin
                cnt_d[r] = '0;
            end else if (wb_dec[r] && (cnt_q[r] == '0)) begin
                // Retiring a register nobody is waiting on: flag it, never wrap.
                err_d    = 1'b1;
                cnt_d[r] = issue_inc[r] ? CNT_W'(1) : '0;
            end else if (issue_inc[r] && !wb_dec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (wb_dec[r] && !issue_inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            mask_d[r] = (cnt_d[r] != '0);
        end
        hcnt_d = hcnt_q;
        if (hazardStallOut && (hcnt_q != 32'hFFFF_FFFF)) begin
            hcnt_d = hcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            mask_q <= '0;
            err_q  <= 1'b0;
            hcnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            mask_q <= mask_d;
            err_q  <= err_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign pendingMaskOut      = mask_q;
    assign busyOut             = |mask_q;
    assign underflowErrOut     = err_q;
    assign hazardCycleCountOut = hcnt_q;

endmodule
